// File: rtl/sh_phase_gen.sv
// Two-phase non-overlapping samp/hold generator with start delay,
// dead time and sample counter. Optional burst mode: SH_BURST_EN.
// Ports: clk, rst (sync, high), en, vdd_ok in; samp, hold, busy,
// samp_done, sample_cnt out; burst_len in when SH_BURST_EN.
module sh_phase_gen #(
  parameter int SAMP_CYC  = 4,
  parameter int HOLD_CYC  = 4,
  parameter int GAP_CYC   = 1,
  parameter int START_DLY = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             vdd_ok,
`ifdef SH_BURST_EN
  input  logic [CNT_W-1:0] burst_len,
`endif
  output logic             samp,
  output logic             hold,
  output logic             busy,
  output logic             samp_done,
  output logic [CNT_W-1:0] sample_cnt
);

  if (GAP_CYC < 1) begin : g_gap_chk
    $error("sh_phase_gen: GAP_CYC must be >= 1");
  end
  if (SAMP_CYC < 1 || HOLD_CYC < 1 || START_DLY < 1) begin : g_cyc_chk
    $error("sh_phase_gen: SAMP/HOLD/START_DLY must be >= 1");
  end

  localparam int M1 = (SAMP_CYC > HOLD_CYC) ? SAMP_CYC : HOLD_CYC;
  localparam int M2 = (M1 > GAP_CYC) ? M1 : GAP_CYC;
  localparam int MX = (M2 > START_DLY) ? M2 : START_DLY;
  localparam int CW = $clog2(MX + 1);

  localparam logic [CW-1:0] L_SAMP = CW'(SAMP_CYC - 1);
  localparam logic [CW-1:0] L_HOLD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] L_GAP  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] L_DLY  = CW'(START_DLY - 1);

`ifdef SH_BURST_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SAMP, S_GAP1, S_HOLD, S_GAP2, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SAMP, S_GAP1, S_HOLD, S_GAP2
  } state_t;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt;
  logic             w_run;
  logic             w_fin;
  logic             w_start;
  logic             w_busy;
  logic             r_samp;
  logic             r_hold;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_scnt;
`ifdef SH_BURST_EN
  logic [CNT_W-1:0] r_blen;
`endif

  assign w_run   = en & vdd_ok;
  assign w_start = (r_state == S_IDLE) & w_run;

  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt + 1'b1;
    w_fin  = 1'b0;
    if (!w_run) begin
      // Losing run aborts any phase; a cut-short samp is not counted.
      w_next = S_IDLE;
      w_cnt  = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_next = S_WAIT;
          w_cnt  = '0;
        end
        S_WAIT: begin
          if (r_cnt == L_DLY) begin
            w_next = S_SAMP;
            w_cnt  = '0;
          end
        end
        S_SAMP: begin
          if (r_cnt == L_SAMP) begin
            w_next = S_GAP1;
            w_cnt  = '0;
            w_fin  = 1'b1;
          end
        end
        S_GAP1: begin
          if (r_cnt == L_GAP) begin
            w_next = S_HOLD;
            w_cnt  = '0;
          end
        end
        S_HOLD: begin
          if (r_cnt == L_HOLD) begin
            w_next = S_GAP2;
            w_cnt  = '0;
          end
        end
        S_GAP2: begin
          if (r_cnt == L_GAP) begin
            w_next = S_SAMP;
            w_cnt  = '0;
`ifdef SH_BURST_EN
            // Count was cleared on start, so it equals pulses in burst.
            if (r_blen != '0 && r_scnt == r_blen)
              w_next = S_DONE;
`endif
          end
        end
`ifdef SH_BURST_EN
        S_DONE: begin
          w_next = S_DONE;
          w_cnt  = '0;
        end
`endif
        default: begin
          w_next = S_IDLE;
          w_cnt  = '0;
        end
      endcase
    end
  end

`ifdef SH_BURST_EN
  assign w_busy = (w_next != S_IDLE) && (w_next != S_DONE);
`else
  assign w_busy = (w_next != S_IDLE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_samp  <= 1'b0;
      r_hold  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_scnt  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      // Decoding the next state keeps samp/hold exclusive by construction.
      r_samp  <= (w_next == S_SAMP);
      r_hold  <= (w_next == S_HOLD);
      r_busy  <= w_busy;
      r_done  <= w_fin;
      if (w_start)
        r_scnt <= '0;
      else if (w_fin)
        r_scnt <= r_scnt + 1'b1;
    end
  end

`ifdef SH_BURST_EN
  always_ff @(posedge clk) begin
    if (rst)
      r_blen <= '0;
    else if (w_start)
      r_blen <= burst_len;
  end
`endif

  assign samp       = r_samp;
  assign hold       = r_hold;
  assign busy       = r_busy;
  assign samp_done  = r_done;
  assign sample_cnt = r_scnt;

endmodule

// File: tb/tb_sh_phase_gen.sv
// Bench for sh_phase_gen: timeline reference model + done scoreboard.
// Two instances share stimulus: default width and CNT_W=4 for wrap.
module tb_sh_phase_gen;

  localparam int S = 4;
  localparam int H = 4;
  localparam int G = 1;
  localparam int D = 8;
  localparam int P = S + H + 2 * G;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        vdd_ok = 1'b1;
  logic [15:0] burst_len = 16'd0;

  logic        samp, hold, busy, samp_done;
  logic [15:0] sample_cnt;
  logic        samp4, hold4, busy4, done4;
  logic [3:0]  cnt4;

  sh_phase_gen dut (
    .clk(clk), .rst(rst), .en(en), .vdd_ok(vdd_ok),
`ifdef SH_BURST_EN
    .burst_len(burst_len),
`endif
    .samp(samp), .hold(hold), .busy(busy),
    .samp_done(samp_done), .sample_cnt(sample_cnt)
  );

  sh_phase_gen #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .vdd_ok(vdd_ok),
`ifdef SH_BURST_EN
    .burst_len(burst_len[3:0]),
`endif
    .samp(samp4), .hold(hold4), .busy(busy4),
    .samp_done(done4), .sample_cnt(cnt4)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: mode 0 idle, 1 running, 2 burst finished.
  // m_t counts cycles since run qualified; phases follow from arithmetic.
  int m_mode = 0;
  int m_t = 0;
  int m_cnt = 0;
  int m_blen = 0;
  bit m_done = 1'b0;
  int sb[$];

  function automatic int ph();
    return (m_t - D) % P;
  endfunction

  function automatic bit e_samp();
    return m_mode == 1 && m_t >= D && ph() < S;
  endfunction

  function automatic bit e_hold();
    return m_mode == 1 && m_t >= D && ph() >= S + G && ph() < S + G + H;
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_mode = 0;
      m_t = 0;
      m_cnt = 0;
    end else if (!(en && vdd_ok)) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
      m_t = 0;
      m_cnt = 0;
`ifdef SH_BURST_EN
      m_blen = int'(burst_len);
`endif
    end else if (m_mode == 1) begin
      m_t++;
      if (m_t >= D && ph() == S) begin
        m_done = 1'b1;
        m_cnt++;
        sb.push_back(m_cnt);
      end
      if (m_blen != 0 && m_t - D == m_blen * P)
        m_mode = 2;
    end
  end

  // Monitor: per-cycle output checks plus scoreboard on samp_done.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("samp", {31'd0, samp}, {31'd0, e_samp()});
      chk("hold", {31'd0, hold}, {31'd0, e_hold()});
      chk("busy", {31'd0, busy}, {31'd0, m_mode == 1});
      chk("samp_done", {31'd0, samp_done}, {31'd0, m_done});
      chk("no_overlap", {31'd0, samp & hold}, 32'd0);
      chk("no_overlap4", {31'd0, samp4 & hold4}, 32'd0);
      chk("done4", {31'd0, done4}, {31'd0, m_done});
      chk("cnt", {16'd0, sample_cnt}, {16'd0, 16'(m_cnt)});
      chk("cnt4", {28'd0, cnt4}, {28'd0, 4'(m_cnt)});
      if (samp_done) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          int e;
          e = sb.pop_front();
          chk("sb_cnt", {16'd0, sample_cnt}, {16'd0, 16'(e)});
          chk("sb_cnt4", {28'd0, cnt4}, {28'd0, 4'(e)});
        end
      end else if (sb.size() != 0) begin
        void'(sb.pop_front());
        chk("sb_missing_done", 32'd0, 32'd1);
      end
    end
  end

  function automatic bit cond(input int w);
    case (w)
      0: return e_samp() && ph() == 1;
      1: return e_hold();
      2: return m_cnt >= 100;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int w, input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cond(w)) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL timeout_%s: condition not reached in %0d cycles", nm, budget);
  endtask

  initial begin
    int c0;
    @(negedge clk);
    chk_on = 1'b1;
    chk("rst_samp", {31'd0, samp}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", {16'd0, sample_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    // First rise exactly START_DLY edges after qualification.
    repeat (8) @(negedge clk);
    chk("pre_rise", {31'd0, samp}, 32'd0);
    @(negedge clk);
    chk("first_rise", {31'd0, samp}, 32'd1);
    repeat (4) @(negedge clk);
    chk("first_fall", {31'd0, samp}, 32'd0);
    chk("first_done", {31'd0, samp_done}, 32'd1);
    chk("first_cnt", {16'd0, sample_cnt}, 32'd1);
    repeat (2) @(negedge clk);
    chk("first_hold", {31'd0, hold}, 32'd1);

    wait_for(2, 1200, "100_periods");
    repeat (3) @(negedge clk);
    chk("cnt_100", {16'd0, sample_cnt}, 32'd100);
    chk("cnt4_wrap", {28'd0, cnt4}, 32'd4);

    // Abort in the second samp cycle.
    wait_for(0, 40, "samp2");
    c0 = m_cnt;
    en = 1'b0;
    @(negedge clk);
    chk("abort_samp", {31'd0, samp}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_nodone", {31'd0, samp_done}, 32'd0);
    chk("abort_cnt", {16'd0, sample_cnt}, {16'd0, 16'(c0)});
    repeat (5) @(negedge clk);
    chk("idle_hold_cnt", {16'd0, sample_cnt}, {16'd0, 16'(c0)});
    en = 1'b1;

    // Supply drop during hold, then immediate recovery.
    wait_for(1, 40, "hold");
    vdd_ok = 1'b0;
    @(negedge clk);
    chk("vdd_hold", {31'd0, hold}, 32'd0);
    vdd_ok = 1'b1;
    repeat (8) @(negedge clk);
    chk("restart_pre", {31'd0, samp}, 32'd0);
    chk("restart_cnt", {16'd0, sample_cnt}, 32'd0);
    @(negedge clk);
    chk("restart_rise", {31'd0, samp}, 32'd1);

`ifdef SH_BURST_EN
    en = 1'b0;
    burst_len = 16'd3;
    @(negedge clk);
    en = 1'b1;
    repeat (8 + 3 * P + 6) @(negedge clk);
    chk("burst_busy", {31'd0, busy}, 32'd0);
    chk("burst_cnt", {16'd0, sample_cnt}, 32'd3);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (9) @(negedge clk);
    chk("burst_again", {31'd0, samp}, 32'd1);
`endif

    // Random run/supply/reset activity checked by the monitor.
    for (int k = 0; k < 60; k++) begin
      int act;
      act = $urandom_range(0, 9);
`ifdef SH_BURST_EN
      if (!en) burst_len = 16'($urandom_range(0, 4));
`endif
      if (act < 4) en = ~en;
      else if (act < 7) vdd_ok = ~vdd_ok;
      else if (act == 7) rst = 1'b1;
      else begin
        en = 1'b1;
        vdd_ok = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      repeat ($urandom_range(0, 45)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
